x1spi_slave: RTL and testbench

Single-lane SPI responder (mode 0) that sits on the far end of the `x1spi` master bus and mirrors its frame format: 8-bit command, 24-bit address, `dummy_num` dummy bytes, then a data phase. It receives the master's `sclk`, `cs_n` and serial output, decodes the header, and either returns read bytes fetched from a local byte source or delivers written bytes to local logic. It is used as a synthesizable flash/peripheral stand-in for loopback tests of `x1spi` and as a real slave port in FPGA builds.

---
 rtl/x1spi_slave.sv | 249 ++++++++++++++++++++++++
 tb/tb_x1spi_slave.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x1spi_slave.sv
// x1spi_slave
// Single-lane SPI mode-0 responder matching the x1spi master frame format:
// 8-bit command, 24-bit address, dummy_num_i dummy bytes, then a data phase.
// The command WR_CMD selects a write data phase. Every other command selects
// a read data phase, which streams bytes until chip select deasserts.
//
// Ports
//   clk_i        system clock (sclk_i must be at most clk_i/16)
//   rst_n_i      asynchronous active-low reset
//   sclk_i       SPI clock from master, idle low (asynchronous)
//   cs_n_i       SPI chip select, active low (asynchronous)
//   mosi_i       serial data from master, MSB first
//   miso_o       serial data to master, MSB first
//   dummy_num_i  dummy byte count 0-7, sampled at frame start
//   cmd_o        last received command byte
//   addr_o       last received address
//   hdr_valid_o  one-cycle pulse when cmd_o/addr_o of a frame are complete
//   rd_req_o     one-cycle pulse requesting the next read byte
//   rd_data_i    read byte, stable 2 clk_i cycles after rd_req_o
//   wr_data_o    received write byte
//   wr_valid_o   one-cycle pulse, wr_data_o valid
//   frame_end_o  one-cycle pulse when cs_n_i deasserts during a frame
//   busy_o       high while a frame is in progress
module x1spi_slave #(
   parameter logic [7:0] WR_CMD = 8'h02
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        sclk_i,
   input  logic        cs_n_i,
   input  logic        mosi_i,
   output logic        miso_o,
   input  logic [2:0]  dummy_num_i,
   output logic [7:0]  cmd_o,
   output logic [23:0] addr_o,
   output logic        hdr_valid_o,
   output logic        rd_req_o,
   input  logic [7:0]  rd_data_i,
   output logic [7:0]  wr_data_o,
   output logic        wr_valid_o,
   output logic        frame_end_o,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DUMMY,
      S_RD_DATA,
      S_WR_DATA
   } state_t;

   // Synchronizer chains: bit 0 = first flop, bit 1 = second flop,
   // bit 2 = edge-detect / alignment register.
   logic [2:0]  sclk_s_q;
   logic [2:0]  cs_s_q;
   logic [2:0]  mosi_s_q;
   logic        rise_d, fall_d;
   logic        rise_q, fall_q;
   logic        cs_hi;
   logic        cs_fall;
   logic        mosi_bit;

   state_t      state_q;
   logic [2:0]  bit_cnt_q;
   logic [2:0]  byte_cnt_q;     // address bytes in ADDR, dummy bytes in DUMMY
   logic [2:0]  dnum_q;
   logic [22:0] sh_q;           // receive shifter; incoming bit completes it
   logic [7:0]  tx_q;
   logic        miso_q;
   logic [7:0]  cmd_q;
   logic [23:0] addr_q;
   logic [7:0]  wr_data_q;
   logic        hdr_valid_q;
   logic        wr_valid_q;
   logic        frame_end_q;
   logic        busy_q;
   logic        req_pend_q;     // read byte needed; rd_req_o follows next cycle
   logic        rd_req_q;
   logic        ld_q;           // rd_data_i is loaded into tx_q the cycle after

   assign rise_d   = sclk_s_q[1] & ~sclk_s_q[2];
   assign fall_d   = ~sclk_s_q[1] & sclk_s_q[2];
   assign cs_hi    = cs_s_q[1];
   assign cs_fall  = cs_s_q[2] & ~cs_s_q[1];
   // Delayed one extra cycle so the sampled bit lines up with rise_q.
   assign mosi_bit = mosi_s_q[2];

   // Input synchronization and edge detection
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sclk_s_q <= 3'b000;
         cs_s_q   <= 3'b111;
         mosi_s_q <= 3'b000;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sclk_s_q <= {sclk_s_q[1:0], sclk_i};
         cs_s_q   <= {cs_s_q[1:0], cs_n_i};
         mosi_s_q <= {mosi_s_q[1:0], mosi_i};
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   // Frame FSM with registered outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= 3'd0;
         byte_cnt_q  <= 3'd0;
         dnum_q      <= 3'd0;
         sh_q        <= 23'd0;
         tx_q        <= 8'd0;
         miso_q      <= 1'b0;
         cmd_q       <= 8'd0;
         addr_q      <= 24'd0;
         wr_data_q   <= 8'd0;
         hdr_valid_q <= 1'b0;
         wr_valid_q  <= 1'b0;
         frame_end_q <= 1'b0;
         busy_q      <= 1'b0;
         req_pend_q  <= 1'b0;
         rd_req_q    <= 1'b0;
         ld_q        <= 1'b0;
      end else begin
         hdr_valid_q <= 1'b0;
         wr_valid_q  <= 1'b0;
         frame_end_q <= 1'b0;
         req_pend_q  <= 1'b0;
         rd_req_q    <= req_pend_q;
         ld_q        <= rd_req_q;

         // Chip select release wins over any edge seen in the same cycle,
         // so a byte completing together with the release is dropped.
         if (state_q != S_IDLE && cs_hi) begin
            state_q     <= S_IDLE;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_end_q <= 1'b1;
            rd_req_q    <= 1'b0;
            ld_q        <= 1'b0;
         end else begin
            if (ld_q) begin
               tx_q <= rd_data_i;
            end
            case (state_q)
               S_IDLE: begin
                  if (cs_fall) begin
                     state_q    <= S_CMD;
                     bit_cnt_q  <= 3'd0;
                     byte_cnt_q <= 3'd0;
                     dnum_q     <= dummy_num_i;
                     busy_q     <= 1'b1;
                     tx_q       <= 8'd0;
                     miso_q     <= 1'b0;
                  end
               end
               S_CMD: begin
                  if (rise_q) begin
                     sh_q      <= {sh_q[21:0], mosi_bit};
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        cmd_q      <= {sh_q[6:0], mosi_bit};
                        byte_cnt_q <= 3'd0;
                        state_q    <= S_ADDR;
                     end
                  end
               end
               S_ADDR: begin
                  if (rise_q) begin
                     sh_q      <= {sh_q[21:0], mosi_bit};
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q == 3'd2) begin
                           addr_q      <= {sh_q, mosi_bit};
                           hdr_valid_q <= 1'b1;
                           byte_cnt_q  <= 3'd0;
                           if (cmd_q == WR_CMD) begin
                              state_q <= S_WR_DATA;
                           end else if (dnum_q != 3'd0) begin
                              state_q <= S_DUMMY;
                           end else begin
                              state_q    <= S_RD_DATA;
                              req_pend_q <= 1'b1;
                           end
                        end else begin
                           byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                     end
                  end
               end
               S_DUMMY: begin
                  if (rise_q) begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q == dnum_q - 3'd1) begin
                           state_q    <= S_RD_DATA;
                           req_pend_q <= 1'b1;
                        end else begin
                           byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                     end
                  end
               end
               S_RD_DATA: begin
                  if (rise_q) begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        req_pend_q <= 1'b1;
                     end
                  end
                  // The load lands several clk before the next fall, so the
                  // shift here never collides with it.
                  if (fall_q) begin
                     miso_q <= tx_q[7];
                     tx_q   <= {tx_q[6:0], 1'b0};
                  end
               end
               S_WR_DATA: begin
                  if (rise_q) begin
                     sh_q      <= {sh_q[21:0], mosi_bit};
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        wr_data_q  <= {sh_q[6:0], mosi_bit};
                        wr_valid_q <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign miso_o      = miso_q;
   assign cmd_o       = cmd_q;
   assign addr_o      = addr_q;
   assign hdr_valid_o = hdr_valid_q;
   assign rd_req_o    = rd_req_q;
   assign wr_data_o   = wr_data_q;
   assign wr_valid_o  = wr_valid_q;
   assign frame_end_o = frame_end_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_x1spi_slave.sv
// Bench for x1spi_slave: a bit-level SPI master drives frames, a monitor
// counts output pulses and serves read bytes from a queue, and each test task
// compares against expectations derived from the frame contents.
module tb_x1spi_slave;

   localparam logic [7:0] WR = 8'h02;
   localparam int         H  = 10;   // sclk half period in clk cycles

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclk = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic [2:0]  dummy_num = 3'd0;
   logic [7:0]  cmd;
   logic [23:0] addr;
   logic        hdr_valid;
   logic        rd_req;
   logic [7:0]  rd_data = 8'd0;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        frame_end;
   logic        busy;

   x1spi_slave #(.WR_CMD(WR)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .sclk_i(sclk), .cs_n_i(cs_n),
      .mosi_i(mosi), .miso_o(miso), .dummy_num_i(dummy_num),
      .cmd_o(cmd), .addr_o(addr), .hdr_valid_o(hdr_valid),
      .rd_req_o(rd_req), .rd_data_i(rd_data), .wr_data_o(wr_data),
      .wr_valid_o(wr_valid), .frame_end_o(frame_end), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          hdr_cnt, rd_cnt, fe_cnt, hdr_cyc, first_rd_cyc;
   logic [7:0]  rd_q[$];
   logic [7:0]  wr_seen[$];
   logic [7:0]  wbytes[8];
   logic [7:0]  rbytes[8];
   logic        hdr_miso;
   logic [7:0]  exp_cmd = 8'd0;
   logic [23:0] exp_addr = 24'd0;

   // Pulse monitor and read-byte server
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (hdr_valid) begin hdr_cnt++; hdr_cyc = cyc; end
         if (rd_req) begin
            rd_cnt++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            rd_data = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
         end
         if (wr_valid) wr_seen.push_back(wr_data);
         if (frame_end) fe_cnt++;
      end
   end

   task automatic clr_mon();
      hdr_cnt = 0; rd_cnt = 0; fe_cnt = 0; hdr_cyc = -1; first_rd_cyc = -1;
      wr_seen.delete();
   endtask

   // Bit-level mode-0 master. Sends up to 'cut' bits (whole frame if cut<0),
   // samples miso on each rise, optionally releases cs with the last rise.
   task automatic spi_xfer(input logic [7:0] c, input logic [23:0] a, input int dn,
                           input int nb, input int cut, input bit end_on_rise,
                           input bit raise_cs);
      int   total, nsend, di, hdr_bits;
      logic b;
      total    = 32 + 8*dn + 8*nb;
      hdr_bits = 32 + 8*dn;
      nsend    = (cut >= 0 && cut < total) ? cut : total;
      hdr_miso = 1'b0;
      for (int k = 0; k < 8; k++) rbytes[k] = 8'h00;
      dummy_num = 3'(dn);
      cs_n = 1'b0;
      repeat (H) @(negedge clk);
      for (int i = 0; i < nsend; i++) begin
         di = i - hdr_bits;
         if (i < 8)              b = c[7-i];
         else if (i < 32)        b = a[31-i];
         else if (i < hdr_bits)  b = 1'($urandom_range(0, 1));
         else if (c == WR)       b = wbytes[di/8][7-(di%8)];
         else                    b = 1'($urandom_range(0, 1));
         mosi = b;
         repeat (H) @(negedge clk);
         sclk = 1'b1;
         if (i < hdr_bits) hdr_miso = hdr_miso | miso;
         else              rbytes[di/8][7-(di%8)] = miso;
         if (end_on_rise && i == nsend - 1) cs_n = 1'b1;
         repeat (H) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (H) @(negedge clk);
      if (raise_cs) cs_n = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++; if (miso !== 1'b0)      begin n_fail++; $display("FAIL rst_miso got %b want 0", miso); end
      n_chk++; if (cmd !== 8'h00)      begin n_fail++; $display("FAIL rst_cmd got %h want 00", cmd); end
      n_chk++; if (addr !== 24'h0)     begin n_fail++; $display("FAIL rst_addr got %h want 0", addr); end
      n_chk++; if (wr_data !== 8'h00)  begin n_fail++; $display("FAIL rst_wr_data got %h want 00", wr_data); end
      n_chk++; if ({hdr_valid, rd_req, wr_valid, frame_end, busy} !== 5'b0)
         begin n_fail++; $display("FAIL rst_pulses got %b want 00000", {hdr_valid, rd_req, wr_valid, frame_end, busy}); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      exp_cmd = 8'h00; exp_addr = 24'h0;
   endtask

   task automatic test_read();
      clr_mon(); rd_q.delete();
      rd_q.push_back(8'hA5); rd_q.push_back(8'h3C);
      spi_xfer(8'h55, 24'h111111, 2, 2, -1, 1'b1, 1'b1);
      exp_cmd = 8'h55; exp_addr = 24'h111111;
      n_chk++; if (cmd !== exp_cmd)    begin n_fail++; $display("FAIL read_cmd got %h want %h", cmd, exp_cmd); end
      n_chk++; if (addr !== exp_addr)  begin n_fail++; $display("FAIL read_addr got %h want %h", addr, exp_addr); end
      n_chk++; if (hdr_cnt !== 1)      begin n_fail++; $display("FAIL read_hdr_cnt got %0d want 1", hdr_cnt); end
      n_chk++; if (rd_cnt !== 2)       begin n_fail++; $display("FAIL read_rd_req_cnt got %0d want 2", rd_cnt); end
      n_chk++; if (rbytes[0] !== 8'hA5) begin n_fail++; $display("FAIL read_byte0 got %h want a5", rbytes[0]); end
      n_chk++; if (rbytes[1] !== 8'h3C) begin n_fail++; $display("FAIL read_byte1 got %h want 3c", rbytes[1]); end
      n_chk++; if (hdr_miso !== 1'b0)  begin n_fail++; $display("FAIL read_hdr_miso got %b want 0", hdr_miso); end
      n_chk++; if (fe_cnt !== 1)       begin n_fail++; $display("FAIL read_frame_end got %0d want 1", fe_cnt); end
      n_chk++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL read_busy got %b want 0", busy); end
      n_chk++; if (wr_seen.size() !== 0) begin n_fail++; $display("FAIL read_wr_cnt got %0d want 0", wr_seen.size()); end
   endtask

   task automatic test_write();
      clr_mon();
      wbytes[0] = 8'hDE; wbytes[1] = 8'hAD;
      spi_xfer(WR, 24'h000010, 0, 2, -1, 1'b0, 1'b1);
      exp_cmd = WR; exp_addr = 24'h000010;
      n_chk++; if (hdr_cnt !== 1)      begin n_fail++; $display("FAIL write_hdr_cnt got %0d want 1", hdr_cnt); end
      n_chk++; if (addr !== exp_addr)  begin n_fail++; $display("FAIL write_addr got %h want %h", addr, exp_addr); end
      n_chk++; if (wr_seen.size() !== 2) begin n_fail++; $display("FAIL write_cnt got %0d want 2", wr_seen.size()); end
      else begin
         n_chk++; if (wr_seen[0] !== 8'hDE) begin n_fail++; $display("FAIL write_b0 got %h want de", wr_seen[0]); end
         n_chk++; if (wr_seen[1] !== 8'hAD) begin n_fail++; $display("FAIL write_b1 got %h want ad", wr_seen[1]); end
      end
      n_chk++; if (rd_cnt !== 0)       begin n_fail++; $display("FAIL write_rd_req got %0d want 0", rd_cnt); end
      n_chk++; if (fe_cnt !== 1)       begin n_fail++; $display("FAIL write_frame_end got %0d want 1", fe_cnt); end
   endtask

   task automatic test_no_dummy();
      logic [23:0] a;
      a = 24'($urandom);
      clr_mon(); rd_q.delete();
      rd_q.push_back(8'h81);
      spi_xfer(8'h0B, a, 0, 1, -1, 1'b1, 1'b1);
      exp_cmd = 8'h0B; exp_addr = a;
      n_chk++; if (addr !== exp_addr)  begin n_fail++; $display("FAIL nodum_addr got %h want %h", addr, exp_addr); end
      n_chk++; if (rbytes[0] !== 8'h81) begin n_fail++; $display("FAIL nodum_byte got %h want 81", rbytes[0]); end
      n_chk++; if (first_rd_cyc - hdr_cyc !== 1)
         begin n_fail++; $display("FAIL nodum_req_lag got %0d want 1", first_rd_cyc - hdr_cyc); end
      n_chk++; if (rd_cnt !== 1)       begin n_fail++; $display("FAIL nodum_rd_cnt got %0d want 1", rd_cnt); end
   endtask

   task automatic test_abort();
      logic [23:0] a;
      clr_mon(); rd_q.delete();
      spi_xfer(8'h9F, 24'hABCDEF, 0, 1, 28, 1'b0, 1'b1);
      exp_cmd = 8'h9F;
      n_chk++; if (hdr_cnt !== 0)      begin n_fail++; $display("FAIL abort_hdr got %0d want 0", hdr_cnt); end
      n_chk++; if (fe_cnt !== 1)       begin n_fail++; $display("FAIL abort_frame_end got %0d want 1", fe_cnt); end
      n_chk++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
      n_chk++; if (cmd !== exp_cmd)    begin n_fail++; $display("FAIL abort_cmd got %h want %h", cmd, exp_cmd); end
      n_chk++; if (addr !== exp_addr)  begin n_fail++; $display("FAIL abort_addr_hold got %h want %h", addr, exp_addr); end
      clr_mon();
      a = 24'($urandom);
      wbytes[0] = 8'($urandom);
      spi_xfer(WR, a, 0, 1, -1, 1'b0, 1'b1);
      exp_cmd = WR; exp_addr = a;
      n_chk++; if (hdr_cnt !== 1)      begin n_fail++; $display("FAIL abort_next_hdr got %0d want 1", hdr_cnt); end
      n_chk++; if (addr !== exp_addr)  begin n_fail++; $display("FAIL abort_next_addr got %h want %h", addr, exp_addr); end
      n_chk++; if (wr_seen.size() !== 1 || wr_seen[0] !== wbytes[0])
         begin n_fail++; $display("FAIL abort_next_wr got n=%0d want byte %h", wr_seen.size(), wbytes[0]); end
   endtask

   task automatic test_reset_mid_read();
      logic [23:0] a;
      clr_mon(); rd_q.delete();
      rd_q.push_back(8'($urandom)); rd_q.push_back(8'($urandom));
      spi_xfer(8'h03, 24'h123456, 1, 2, 52, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      n_chk++; if ({miso, hdr_valid, rd_req, wr_valid, frame_end, busy} !== 6'b0)
         begin n_fail++; $display("FAIL midrst_bits got %b want 000000", {miso, hdr_valid, rd_req, wr_valid, frame_end, busy}); end
      n_chk++; if ({cmd, addr, wr_data} !== 40'h0)
         begin n_fail++; $display("FAIL midrst_regs got %h want 0", {cmd, addr, wr_data}); end
      cs_n = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      clr_mon(); rd_q.delete();
      a = 24'($urandom);
      rd_q.push_back(8'h6E); rd_q.push_back(8'h00);
      spi_xfer(8'h3B, a, 1, 1, -1, 1'b0, 1'b1);
      exp_cmd = 8'h3B; exp_addr = a;
      n_chk++; if (cmd !== exp_cmd || addr !== exp_addr)
         begin n_fail++; $display("FAIL midrst_next_hdr got %h/%h want %h/%h", cmd, addr, exp_cmd, exp_addr); end
      n_chk++; if (rbytes[0] !== 8'h6E) begin n_fail++; $display("FAIL midrst_next_byte got %h want 6e", rbytes[0]); end
   endtask

   task automatic test_idle_noise();
      clr_mon();
      cs_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         mosi = 1'($urandom_range(0, 1));
         repeat (H) @(negedge clk); sclk = 1'b1;
         repeat (H) @(negedge clk); sclk = 1'b0;
      end
      repeat (10) @(negedge clk);
      n_chk++; if (hdr_cnt + rd_cnt + fe_cnt + wr_seen.size() !== 0)
         begin n_fail++; $display("FAIL noise_pulses got %0d want 0", hdr_cnt + rd_cnt + fe_cnt + wr_seen.size()); end
      n_chk++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL noise_busy got %b want 0", busy); end
      n_chk++; if (cmd !== exp_cmd || addr !== exp_addr)
         begin n_fail++; $display("FAIL noise_hold got %h/%h want %h/%h", cmd, addr, exp_cmd, exp_addr); end
   endtask

   // Random frames back to back; reads release cs after the last fall, so
   // one prefetch request follows the final byte.
   task automatic test_back_to_back();
      logic [7:0]  c;
      logic [23:0] a;
      logic [7:0]  exp_rd[8];
      int          dn, nb;
      for (int f = 0; f < 8; f++) begin
         c  = ($urandom_range(0, 1) == 1) ? WR : 8'($urandom);
         a  = 24'($urandom);
         dn = (c == WR) ? 0 : int'($urandom_range(0, 3));
         nb = int'($urandom_range(1, 3));
         clr_mon(); rd_q.delete();
         for (int k = 0; k <= nb; k++) begin
            exp_rd[k] = 8'($urandom);
            rd_q.push_back(exp_rd[k]);
            wbytes[k] = 8'($urandom);
         end
         spi_xfer(c, a, dn, nb, -1, 1'b0, 1'b1);
         exp_cmd = c; exp_addr = a;
         n_chk++; if (cmd !== exp_cmd || addr !== exp_addr || hdr_cnt !== 1)
            begin n_fail++; $display("FAIL b2b_hdr f%0d got %h/%h n=%0d want %h/%h n=1", f, cmd, addr, hdr_cnt, exp_cmd, exp_addr); end
         n_chk++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL b2b_frame_end f%0d got %0d want 1", f, fe_cnt); end
         if (c == WR) begin
            n_chk++; if (wr_seen.size() !== nb || rd_cnt !== 0)
               begin n_fail++; $display("FAIL b2b_wr_cnt f%0d got %0d/%0d want %0d/0", f, wr_seen.size(), rd_cnt, nb); end
            for (int k = 0; k < nb && k < wr_seen.size(); k++) begin
               n_chk++; if (wr_seen[k] !== wbytes[k])
                  begin n_fail++; $display("FAIL b2b_wr f%0d b%0d got %h want %h", f, k, wr_seen[k], wbytes[k]); end
            end
         end else begin
            n_chk++; if (rd_cnt !== nb + 1)
               begin n_fail++; $display("FAIL b2b_rd_cnt f%0d got %0d want %0d", f, rd_cnt, nb + 1); end
            n_chk++; if (hdr_miso !== 1'b0)
               begin n_fail++; $display("FAIL b2b_hdr_miso f%0d got %b want 0", f, hdr_miso); end
            for (int k = 0; k < nb; k++) begin
               n_chk++; if (rbytes[k] !== exp_rd[k])
                  begin n_fail++; $display("FAIL b2b_rd f%0d b%0d got %h want %h", f, k, rbytes[k], exp_rd[k]); end
            end
         end
      end
   endtask

   initial begin
      clr_mon();
      test_reset();
      test_read();
      test_write();
      test_no_dummy();
      test_abort();
      test_idle_noise();
      test_reset_mid_read();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
